// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: gated one-hot active-low decoder with a direct mode and an auto-scan FSM (SCAN_BLANK_EN adds a blank cycle between outputs)
module decoder_scan_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            en_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  start,
  output logic [2**SEL_W-1:0]   D_n,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);
  localparam int N = 2**SEL_W;
`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, HOLD, BLANK} state_t;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif
  state_t state, state_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] idx_nx, idx_inc;
  logic [N-1:0] d_nx;
  logic wrap_nx, act;
  function automatic logic [N-1:0] onehot_n(input logic [SEL_W-1:0] s);
    return ~({{(N-1){1'b0}}, 1'b1} << s);
  endfunction
  assign act = en & ~en_n[0] & ~en_n[1];
  assign idx_inc = idx + 1'b1;
  assign busy = state != IDLE;
  // D_n is registered from the next-state view so it changes on the same edge as idx
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    cnt_nx = cnt;
    wrap_nx = 1'b0;
    d_nx = '1;
    case (state)
      IDLE: begin
        if (mode && start) begin
          state_nx = HOLD;
          idx_nx = '0;
          cnt_nx = dwell;
          d_nx = act ? onehot_n('0) : '1;
        end else if (!mode) d_nx = act ? onehot_n(sel) : '1;
      end
      HOLD: begin
        if (!mode) begin
          state_nx = IDLE;
          idx_nx = '0;
          cnt_nx = '0;
          d_nx = act ? onehot_n(sel) : '1;
        end else if (act) begin
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
            d_nx = onehot_n(idx);
          end else begin
`ifdef SCAN_BLANK_EN
            state_nx = BLANK;
`else
            idx_nx = idx_inc;
            cnt_nx = dwell;
            wrap_nx = &idx;
            d_nx = onehot_n(idx_inc);
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (!mode) begin
          state_nx = IDLE;
          idx_nx = '0;
          cnt_nx = '0;
          d_nx = act ? onehot_n(sel) : '1;
        end else if (act) begin
          state_nx = HOLD;
          idx_nx = idx_inc;
          cnt_nx = dwell;
          wrap_nx = &idx;
          d_nx = onehot_n(idx_inc);
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      D_n <= '1;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      cnt <= cnt_nx;
      D_n <= d_nx;
      wrap <= wrap_nx;
    end
  end
endmodule
